// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (inst/data) arbiter onto one single-port memory; optional MEM_ARB_ROUND_ROBIN_EN tie policy
`ifndef WORD_ADDRESS_SIZE
`define WORD_ADDRESS_SIZE 32
`endif

package memory_io_pkg;
    typedef struct packed {
        logic                          valid;
        logic [`WORD_ADDRESS_SIZE-1:0] addr;
        logic [3:0]                    do_read;
        logic [3:0]                    do_write;
        logic [31:0]                   data;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] data;
    } memory_io_rsp;
endpackage

module mem_arbiter
    import memory_io_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req inst_req,
    output memory_io_rsp inst_rsp,
    input  memory_io_req data_req,
    output memory_io_rsp data_rsp,
    output memory_io_req mem_req,
    input  memory_io_rsp mem_rsp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    state_t       state, state_next;
    memory_io_req cur_req, pend_req;
    logic         cur_owner, pend_owner, pend_valid;
    logic         ready, inst_acc, data_acc, tie, tie_to_data, data_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic         last_tie_data;
`endif

    // Registered copies never carry valid; it is regenerated in ISSUE.
    function automatic memory_io_req capture(input memory_io_req r);
        memory_io_req c;
        c       = r;
        c.valid = 1'b0;
        return c;
    endfunction

    always_comb begin
        state_next  = state;
        ready       = (state == IDLE) && mem_rsp.ready;
        inst_rsp    = '0;
        data_rsp    = '0;
        mem_req     = '0;
        inst_rsp.ready = ready;
        data_rsp.ready = ready;
        inst_acc    = inst_req.valid && ready;
        data_acc    = data_req.valid && ready;
        tie         = inst_acc && data_acc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_to_data = !last_tie_data;
`else
        tie_to_data = 1'b1;
`endif
        data_wins   = tie ? tie_to_data : data_acc;

        case (state)
            IDLE: begin
                if (inst_acc || data_acc)
                    state_next = ISSUE;
            end
            ISSUE: begin
                mem_req       = cur_req;
                mem_req.valid = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                if (mem_rsp.valid) begin
                    if (cur_owner == OWNER_DATA) begin
                        data_rsp.valid = 1'b1;
                        data_rsp.data  = mem_rsp.data;
                    end else begin
                        inst_rsp.valid = 1'b1;
                        inst_rsp.data  = mem_rsp.data;
                    end
                    state_next = pend_valid ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_req    <= '0;
            cur_owner  <= OWNER_INST;
            pend_req   <= '0;
            pend_owner <= OWNER_INST;
            pend_valid <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_tie_data <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (inst_acc || data_acc) begin
                cur_req   <= data_wins ? capture(data_req) : capture(inst_req);
                cur_owner <= data_wins ? OWNER_DATA : OWNER_INST;
                if (tie) begin
                    pend_valid <= 1'b1;
                    pend_req   <= data_wins ? capture(inst_req) : capture(data_req);
                    pend_owner <= data_wins ? OWNER_INST : OWNER_DATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_tie_data <= data_wins;
`endif
                end
            end
            // The pending loser is promoted on the winner's response cycle.
            if (state == WAIT && mem_rsp.valid && pend_valid) begin
                cur_req    <= pend_req;
                cur_owner  <= pend_owner;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table + scoreboard)
module tb_mem_arbiter;
    import memory_io_pkg::*;

    localparam int AW = `WORD_ADDRESS_SIZE;

    logic         clk = 1'b0;
    logic         reset;
    memory_io_req inst_req, data_req, mem_req;
    memory_io_rsp inst_rsp, data_rsp, mem_rsp;
    logic         mem_valid = 1'b0, mem_ready = 1'b1;
    logic [31:0]  mem_data = '0;

    assign mem_rsp = {mem_valid, mem_ready, mem_data};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .inst_req (inst_req),
        .inst_rsp (inst_rsp),
        .data_req (data_req),
        .data_rsp (data_rsp),
        .mem_req  (mem_req),
        .mem_rsp  (mem_rsp)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    rd;
        logic [3:0]    wr;
        logic [31:0]   data;
    } mreq_t;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        bit          iv;
        logic [31:0] ia;
        bit          dv;
        logic [31:0] da;
        logic [3:0]  drd;
        logic [3:0]  dwr;
        logic [31:0] dd;
        int          lat;
        bit          exp_data_first;
    } vec_t;

    mreq_t         mem_q[$];
    rsp_t          rsp_q[$];
    int            checks = 0, errors = 0;
    int            mem_lat = 3, cnt = 0;
    logic [AW-1:0] pend_addr;
    bit            chk_ready = 1'b0, expect_issue = 1'b0, rr_last_data = 1'b0;
    bit            use_override = 1'b0;
    logic [31:0]   override_data = '0;

    function automatic logic [31:0] rdata(input logic [AW-1:0] a);
        return 32'h00500093 ^ ((32'(a) - 32'h40) * 32'h9E3779B9);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model and output monitor.
    always @(negedge clk) begin
        mreq_t e;
        rsp_t  r;
        mem_valid = 1'b0;
        mem_data  = '0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = use_override ? override_data : rdata(pend_addr);
            end
        end
        #1;
        if (chk_ready)
            check("ready", {inst_rsp.ready, data_rsp.ready},
                  (mem_ready && mem_q.size() == 0 && rsp_q.size() == 0) ? 2'b11 : 2'b00);
        if (expect_issue) begin
            check("issue_latency", mem_req.valid, 1'b1);
            expect_issue = 1'b0;
        end
        if (mem_req.valid) begin
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_req_unexpected: got addr %h expected no request", mem_req.addr);
            end else begin
                e = mem_q.pop_front();
                check("mem_addr", 64'(mem_req.addr), 64'(e.addr));
                check("mem_rd_wr_data", {mem_req.do_read, mem_req.do_write, mem_req.data},
                      {e.rd, e.wr, e.data});
            end
            cnt       = mem_lat;
            pend_addr = mem_req.addr;
        end else begin
            checks++;
            if (mem_req !== '0) begin
                errors++;
                $display("FAIL mem_req_idle: got %h expected 0", mem_req);
            end
        end
        check("rsp_exclusive", {inst_rsp.valid && data_rsp.valid}, 1'b0);
        if (inst_rsp.valid || data_rsp.valid) begin
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got inst %b data %b expected none",
                         inst_rsp.valid, data_rsp.valid);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_client", data_rsp.valid, r.is_data);
                check("rsp_data", data_rsp.valid ? data_rsp.data : inst_rsp.data, r.data);
            end
        end
    end

    task automatic issue(input vec_t v);
        bit    data_first;
        mreq_t mi, md;
        rsp_t  ri, rd;
        mem_lat = v.lat;
        @(negedge clk);
        inst_req = '{valid: v.iv, addr: v.ia[AW-1:0], do_read: 4'hF, do_write: 4'h0, data: 32'h0};
        data_req = '{valid: v.dv, addr: v.da[AW-1:0], do_read: v.drd, do_write: v.dwr, data: v.dd};
        @(posedge clk);
        mi = '{addr: v.ia[AW-1:0], rd: 4'hF, wr: 4'h0, data: 32'h0};
        md = '{addr: v.da[AW-1:0], rd: v.drd, wr: v.dwr, data: v.dd};
        ri = '{is_data: 1'b0, data: rdata(v.ia[AW-1:0])};
        rd = '{is_data: 1'b1, data: rdata(v.da[AW-1:0])};
        if (v.iv && v.dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            data_first   = !rr_last_data;
            rr_last_data = data_first;
`else
            data_first = v.exp_data_first;
`endif
            if (data_first) begin
                mem_q.push_back(md); mem_q.push_back(mi);
                rsp_q.push_back(rd); rsp_q.push_back(ri);
            end else begin
                mem_q.push_back(mi); mem_q.push_back(md);
                rsp_q.push_back(ri); rsp_q.push_back(rd);
            end
        end else if (v.dv) begin
            mem_q.push_back(md); rsp_q.push_back(rd);
        end else if (v.iv) begin
            mem_q.push_back(mi); rsp_q.push_back(ri);
        end
        expect_issue = v.iv || v.dv;
        #1;
        inst_req = '0;
        data_req = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mem_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_q.size() != 0 || rsp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d/%0d outstanding expected 0/0", mem_q.size(), rsp_q.size());
            mem_q.delete();
            rsp_q.delete();
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        vecs[0] = '{1, 32'h40,  0, 32'h0,   4'h0, 4'h0, 32'h0,        3, 1};
        vecs[1] = '{1, 32'h44,  1, 32'h100, 4'hF, 4'h0, 32'h0,        2, 1};
        vecs[2] = '{0, 32'h0,   1, 32'h200, 4'h0, 4'h3, 32'hDEADBEEF, 1, 1};
        vecs[3] = '{1, 32'h48,  1, 32'h104, 4'hC, 4'h0, 32'h0,        1, 1};
        vecs[4] = '{1, 32'h4C,  1, 32'h300, 4'h0, 4'hF, 32'hA5A55A5A, 4, 1};
        vecs[5] = '{0, 32'h0,   1, 32'h108, 4'h1, 4'h0, 32'h0,        2, 1};

        inst_req = '0;
        data_req = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_ready = 1'b1;
        #2;
        check("reset_ready", {inst_rsp.ready, data_rsp.ready}, 2'b11);
        check("reset_valids", {inst_rsp.valid, data_rsp.valid, mem_req.valid}, 3'b000);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i]);
            wait_idle();
        end

        // Reset taken mid-WAIT: the late memory response must be dropped.
        v = '{1, 32'h80, 0, 32'h0, 4'h0, 4'h0, 32'h0, 6, 1};
        issue(v);
        repeat (3) @(negedge clk);
        chk_ready = 1'b0;
        use_override  = 1'b1;
        override_data = 32'h00001234;
        reset = 1'b1;
        mem_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rr_last_data = 1'b0;
        repeat (8) @(negedge clk);
        chk_ready = 1'b1;
        use_override = 1'b0;
        #2;
        check("post_reset_ready", {inst_rsp.ready, data_rsp.ready}, 2'b11);
        check("post_reset_valids", {inst_rsp.valid, data_rsp.valid}, 2'b00);

        // Memory backpressure: nothing may be accepted or issued.
        @(negedge clk);
        mem_ready = 1'b0;
        inst_req  = '{valid: 1'b1, addr: AW'(32'h50), do_read: 4'hF, do_write: 4'h0, data: 32'h0};
        data_req  = '{valid: 1'b1, addr: AW'(32'h400), do_read: 4'hF, do_write: 4'h0, data: 32'h0};
        repeat (4) begin
            @(negedge clk);
            #2;
            check("bp_ready", {inst_rsp.ready, data_rsp.ready}, 2'b00);
            check("bp_mem_valid", mem_req.valid, 1'b0);
        end
        inst_req  = '0;
        data_req  = '0;
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);

        v = '{1, 32'h54, 0, 32'h0, 4'h0, 4'h0, 32'h0, 2, 1};
        issue(v);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
